// File: rtl/multi_channel_phase_tick_gen.sv
// multi_channel_phase_tick_gen: NUM_CH independent NCO tick generators with wrap-aligned config updates
// Ports:
//   clk, rst_n                          system clock, asynchronous active-low reset
//   enable_i                            accumulators advance while high
//   sync_i                              one-cycle pulse realigning every channel to phase 0
//   cfg_valid_i / cfg_ready_o           config handshake; ready is low while cfg_ch_i has a write pending
//   cfg_ch_i, cfg_inc_i, cfg_off_i      target channel, new increment, new phase offset
//   baud_tick_o / baud_tick_offset_o    one-cycle pulse per period, primary / offset phase
//   gen_clock_o / gen_clock_offset_o    registered accumulator MSB, primary / offset phase
module multi_channel_phase_tick_gen #(
    parameter int NUM_CH           = 4,
    parameter int ACC_WIDTH        = 32,
    parameter int SYS_CLK_FREQ     = 125000000,
    parameter int BAUD_RATE        = 115200,
    parameter int PHASE_OFFSET_DEG = 180,
    localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 sync_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CH_W-1:0]      cfg_ch_i,
    input  logic [ACC_WIDTH-2:0] cfg_inc_i,
    input  logic [ACC_WIDTH-1:0] cfg_off_i,
    output logic [NUM_CH-1:0]    baud_tick_o,
    output logic [NUM_CH-1:0]    baud_tick_offset_o,
    output logic [NUM_CH-1:0]    gen_clock_o,
    output logic [NUM_CH-1:0]    gen_clock_offset_o
);
    localparam int W = ACC_WIDTH;
    // 96-bit intermediates keep BAUD_RATE * 2**W exact up to W = 48
    localparam logic [95:0]  INC_FULL    = (96'(BAUD_RATE) << W) / 96'(SYS_CLK_FREQ);
    localparam logic [95:0]  OFF_FULL    = (96'(PHASE_OFFSET_DEG) << W) / 96'd360;
    localparam logic [W-2:0] DEFAULT_INC = INC_FULL[W-2:0];
    localparam logic [W-1:0] DEFAULT_OFF = OFF_FULL[W-1:0];

    logic [NUM_CH-1:0][W-1:0] acc_q, acc_d, off_q, off_d, sh_off_q, sh_off_d;
    logic [NUM_CH-1:0][W-2:0] inc_q, inc_d, sh_inc_q, sh_inc_d;
    logic [NUM_CH-1:0][W:0]   sum;
    logic [NUM_CH-1:0]        pend_q, pend_d, p_q, p_d, q_q, q_d, bt_q, bt_d, bto_q, bto_d;
    logic [NUM_CH-1:0]        sel, wr, apply, p, q;
    logic                     accept;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) sel[c] = cfg_ch_i == CH_W'(c);
        // an out-of-range channel index reads as ready and the write is dropped
        cfg_ready_o = ~|(sel & pend_q);
        accept      = cfg_valid_i & cfg_ready_o;
        for (int c = 0; c < NUM_CH; c++) begin
            sum[c]      = {1'b0, acc_q[c]} + {2'b0, inc_q[c]};
            p[c]        = acc_q[c][W-1];
            q[c]        = 1'((acc_q[c] + off_q[c]) >> (W-1));
            wr[c]       = accept & sel[c];
            // pend_q is only set by an earlier accept, so a wrap in the accept cycle never applies it
            apply[c]    = pend_q[c] & ((enable_i & sum[c][W]) | ~enable_i | sync_i | (inc_q[c] == '0));
            acc_d[c]    = sync_i ? '0 : enable_i ? sum[c][W-1:0] : acc_q[c];
            inc_d[c]    = (wr[c] & sync_i) ? cfg_inc_i : apply[c] ? sh_inc_q[c] : inc_q[c];
            off_d[c]    = (wr[c] & sync_i) ? cfg_off_i : apply[c] ? sh_off_q[c] : off_q[c];
            sh_inc_d[c] = wr[c] ? cfg_inc_i : sh_inc_q[c];
            sh_off_d[c] = wr[c] ? cfg_off_i : sh_off_q[c];
            pend_d[c]   = wr[c] ? ~sync_i : pend_q[c] & ~apply[c];
            // MSB history freezes while disabled so gen clocks hold and no edge is lost on resume
            p_d[c]      = ~sync_i & (enable_i ? p[c] : p_q[c]);
            q_d[c]      = ~sync_i & (enable_i ? q[c] : q_q[c]);
            bt_d[c]     = ~sync_i & enable_i & p_q[c] & ~p[c];
            bto_d[c]    = ~sync_i & enable_i & q_q[c] & ~q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            inc_q    <= {NUM_CH{DEFAULT_INC}};
            off_q    <= {NUM_CH{DEFAULT_OFF}};
            sh_inc_q <= '0;
            sh_off_q <= '0;
            pend_q   <= '0;
            p_q      <= '0;
            q_q      <= '0;
            bt_q     <= '0;
            bto_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            off_q    <= off_d;
            sh_inc_q <= sh_inc_d;
            sh_off_q <= sh_off_d;
            pend_q   <= pend_d;
            p_q      <= p_d;
            q_q      <= q_d;
            bt_q     <= bt_d;
            bto_q    <= bto_d;
        end
    end

    assign baud_tick_o        = bt_q;
    assign baud_tick_offset_o = bto_q;
    assign gen_clock_o        = p_q;
    assign gen_clock_offset_o = q_q;
endmodule

// File: tb/tb_multi_channel_phase_tick_gen.sv
// tb_multi_channel_phase_tick_gen: directed checks of tick timing, staged config, sync, enable and reset
module tb_multi_channel_phase_tick_gen;
    logic       clk = 1'b0;
    logic       rst_n, enable, sync, cfg_valid, cfg_ch, cfg_ready, en32, rdy32;
    logic [6:0] cfg_inc;
    logic [7:0] cfg_off;
    logic [1:0] bt, bto, gc, gco;
    logic [3:0] bt32, bto32, gc32, gco32;
    logic [31:0] c_bt0, c_bto0, c_gc0, c_gco0, c_bt1, c_gc1, c_rdy;
    int errors = 0;
    int checks = 0;
    int first_gc, first_bt;

    always #5 clk = ~clk;

    multi_channel_phase_tick_gen #(.NUM_CH(2), .ACC_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .sync_i(sync),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch),
        .cfg_inc_i(cfg_inc), .cfg_off_i(cfg_off),
        .baud_tick_o(bt), .baud_tick_offset_o(bto), .gen_clock_o(gc), .gen_clock_offset_o(gco)
    );

    multi_channel_phase_tick_gen dut32 (
        .clk(clk), .rst_n(rst_n), .enable_i(en32), .sync_i(1'b0),
        .cfg_valid_i(1'b0), .cfg_ready_o(rdy32), .cfg_ch_i(2'd0),
        .cfg_inc_i(31'd0), .cfg_off_i(32'd0),
        .baud_tick_o(bt32), .baud_tick_offset_o(bto32), .gen_clock_o(gc32), .gen_clock_offset_o(gco32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        c_bt0 = '0; c_bto0 = '0; c_gc0 = '0; c_gco0 = '0; c_bt1 = '0; c_gc1 = '0; c_rdy = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            c_bt0[i] = bt[0]; c_bto0[i] = bto[0]; c_gc0[i] = gc[0]; c_gco0[i] = gco[0];
            c_bt1[i] = bt[1]; c_gc1[i] = gc[1]; c_rdy[i] = cfg_ready;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; enable = 0; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_inc = 0; cfg_off = 0; en32 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {24'd0, bt, bto, gc, gco}, 32'h0);
        check("rst_rdy", cfg_ready, 1);
        check("rst_out32", {16'd0, bt32, bto32, gc32, gco32}, 32'h0);
        rst_n = 1;

        // basic period 4 with 180 degree offset
        cfg_valid = 1; cfg_ch = 0; cfg_inc = 64; cfg_off = 128;
        run(1);
        cfg_valid = 0;
        check("t1_rdy_pend", cfg_ready, 0);
        run(1);
        check("t1_rdy_applied", cfg_ready, 1);
        enable = 1;
        run(12);
        check("t1_bt0", c_bt0, 32'h110);
        check("t1_bto0", c_bto0, 32'h444);
        check("t1_gc0", c_gc0, 32'hCCC);
        check("t1_gco0", c_gco0, 32'h333);
        check("t1_bt1_frozen", c_bt1, 32'h0);

        // mid-period increment change waits for the wrap
        check("t2_rdy_pre", cfg_ready, 1);
        cfg_valid = 1; cfg_inc = 32;
        run(1);
        cfg_valid = 0;
        cfg_ch = 1; #1;
        check("t2_rdy_ch1", cfg_ready, 1);
        cfg_ch = 0; #1;
        check("t2_rdy_ch0", cfg_ready, 0);
        run(20);
        check("t2_gc0", c_gc0, 32'h78786);
        check("t2_bt0", c_bt0, 32'h80808);
        check("t2_rdy", c_rdy, 32'hFFFFC);

        // pending ch0 write applied by sync, ch1 write coincident with sync goes straight to active
        cfg_valid = 1; cfg_ch = 0; cfg_inc = 64; cfg_off = 128;
        run(1);
        sync = 1; cfg_ch = 1; cfg_inc = 96;
        run(1);
        sync = 0; cfg_valid = 0; cfg_ch = 0;
        check("t3_sync_out", {24'd0, bt, bto, gc, gco}, 32'h0);
        check("t3_rdy0", cfg_ready, 1);
        cfg_ch = 1; #1;
        check("t3_rdy1", cfg_ready, 1);
        cfg_ch = 0;
        run(24);
        check("t3_bt0", c_bt0, 32'h111110);
        check("t3_gc0", c_gc0, 32'hCCCCCC);
        check("t3_bt1", c_bt1, 32'h494948);
        check("t3_gc1", c_gc1, 32'hB4B4B4);
        check("t3_bt1_count", $countones(c_bt1), 8);

        // enable low for 10 cycles mid-period
        run(3);
        check("t4_gc_pre", gc[0], 1);
        enable = 0;
        run(10);
        check("t4_gc0_hold", c_gc0, 32'h3FF);
        check("t4_bt0_off", c_bt0, 32'h0);
        check("t4_bto0_off", c_bto0, 32'h0);
        check("t4_bt1_off", c_bt1, 32'h0);
        enable = 1;
        run(8);
        check("t4_bt0_resume", c_bt0, 32'h22);
        check("t4_gc0_resume", c_gc0, 32'h99);

        // accept in the same cycle as a wrap applies at the following wrap
        check("t5_rdy_pre", cfg_ready, 1);
        cfg_valid = 1; cfg_inc = 32;
        run(1);
        cfg_valid = 0;
        run(16);
        check("t5_rdy", c_rdy, 32'hFFF8);
        check("t5_bt0", c_bt0, 32'h1011);

        // asynchronous reset while a write is pending
        cfg_valid = 1; cfg_inc = 64;
        run(1);
        cfg_valid = 0;
        check("t6_gc_pre", gc[0], 1);
        check("t6_rdy_pre", cfg_ready, 0);
        #2;
        rst_n = 0;
        #1;
        check("t6_async_out", {24'd0, bt, bto, gc, gco}, 32'h0);
        check("t6_async_rdy", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1;
        run(8);
        check("t6_bt0_default", c_bt0, 32'h0);
        check("t6_gc0_default", c_gc0, 32'h0);
        check("t6_gco0_default", c_gco0, 32'hFF);
        check("t6_rdy_default", c_rdy, 32'hFF);

        // default 32-bit increment 3958241: MSB first set at acc step 543, first wrap at step 1086
        en32 = 1;
        first_gc = 0;
        first_bt = 0;
        for (int n = 1; n <= 1200 && first_bt == 0; n++) begin
            @(posedge clk);
            #1;
            if (gc32[0] && first_gc == 0) first_gc = n;
            if (bt32[0]) first_bt = n;
        end
        check("w32_gc_first", first_gc, 544);
        check("w32_bt_first", first_bt, 1087);
        check("w32_bt_all", bt32, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
